// File: rtl/dt_pkg.sv
// Shared geometry and state encoding for the distance-map bit packer.
package dt_pkg;
  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int WORD_W = 16;
  localparam int RES_AW = 14;
  localparam int PK_AW  = 10;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NWORD  = NPIX / WORD_W;

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} dt_state_e;
endpackage

// File: rtl/dt_pack_if.sv
// Control, distance-map read and packed-bitmap write signals of dt_pack.
// Optional checksum output exists only when DT_PACK_CHECKSUM_EN is defined.
interface dt_pack_if;
  import dt_pkg::*;
  logic                start;
  logic [7:0]          thr;
  logic                busy;
  logic                done;
  logic                res_rd;
  logic [RES_AW-1:0]   res_addr;
  logic [7:0]          res_di;
  logic                pk_wr;
  logic [PK_AW-1:0]    pk_addr;
  logic [WORD_W-1:0]   pk_do;
`ifdef DT_PACK_CHECKSUM_EN
  logic [WORD_W-1:0]   checksum;

  modport master (input start, thr, res_di,
                  output busy, done, res_rd, res_addr, pk_wr, pk_addr, pk_do, checksum);
  modport slave  (output start, thr, res_di,
                  input busy, done, res_rd, res_addr, pk_wr, pk_addr, pk_do, checksum);
`else
  modport master (input start, thr, res_di,
                  output busy, done, res_rd, res_addr, pk_wr, pk_addr, pk_do);
  modport slave  (output start, thr, res_di,
                  input busy, done, res_rd, res_addr, pk_wr, pk_addr, pk_do);
`endif
endinterface

// File: rtl/dt_pack_shift.sv
// Threshold compare plus MSB-first shift/pack; emits a one-cycle word_vld
// with the completed word, which is then held until the next word.
module dt_pack_shift
  import dt_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         in_vld,
  input  logic [7:0]   in_data,
  input  logic [7:0]   thr,
  output logic         word_vld,
  output logic [W-1:0] word
);
  logic [W-1:0]         sr;
  logic [W-1:0]         sr_nxt;
  logic [$clog2(W)-1:0] cnt;
  logic                 bit_in;

  assign bit_in = (in_data >= thr);
  assign sr_nxt = {sr[W-2:0], bit_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      sr       <= '0;
      cnt      <= '0;
      word_vld <= 1'b0;
      word     <= '0;
    end else begin
      word_vld <= 1'b0;
      if (clr) begin
        sr  <= '0;
        cnt <= '0;
      end else if (in_vld) begin
        sr  <= sr_nxt;
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          word     <= sr_nxt;
          word_vld <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/dt_pack.sv
// Frame sequencer: streams the 128x128 distance map out, packs thresholded
// bits 16 per word. Define DT_PACK_CHECKSUM_EN for the per-frame checksum.
module dt_pack
  import dt_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  dt_pack_if.master io
);
  localparam int SH = $clog2(WORD_W);
  localparam logic [RES_AW-1:0] RES_LAST = RES_AW'(NPIX - 1);
  localparam logic [PK_AW-1:0]  PK_LAST  = PK_AW'(NWORD - 1);

  dt_state_e          state, state_nxt;
  logic [7:0]         thr_q;
  logic [RES_AW-1:0]  res_addr;
  logic [RES_AW-1:0]  rd_addr_d;
  logic               rd_d;
  logic [PK_AW-1:0]   pk_addr;
  logic               word_vld;
  logic [WORD_W-1:0]  word;
  logic               start_ok;

  assign start_ok = (state == IDLE) && io.start;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.start) state_nxt = READ;
      READ:    if (res_addr == RES_LAST) state_nxt = FLUSH;
      FLUSH:   if (word_vld && pk_addr == PK_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rd_d/rd_addr_d track which pixel res_di belongs to (one-cycle read latency)
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q     <= '0;
      res_addr  <= '0;
      rd_d      <= 1'b0;
      rd_addr_d <= '0;
      pk_addr   <= '0;
    end else begin
      rd_d      <= io.res_rd;
      rd_addr_d <= res_addr;
      if (start_ok) begin
        thr_q    <= io.thr;
        res_addr <= '0;
      end else if (state == READ && res_addr != RES_LAST) begin
        res_addr <= res_addr + 1'b1;
      end
      if (rd_d && &rd_addr_d[SH-1:0])
        pk_addr <= rd_addr_d[RES_AW-1:SH];
    end
  end

  dt_pack_shift #(.W(WORD_W)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .clr      (start_ok),
    .in_vld   (rd_d),
    .in_data  (io.res_di),
    .thr      (thr_q),
    .word_vld (word_vld),
    .word     (word)
  );

  assign io.busy     = (state == READ) || (state == FLUSH);
  assign io.done     = (state == DONE);
  assign io.res_rd   = (state == READ);
  assign io.res_addr = res_addr;
  assign io.pk_wr    = word_vld;
  assign io.pk_addr  = pk_addr;
  assign io.pk_do    = word;

`ifdef DT_PACK_CHECKSUM_EN
  logic [WORD_W-1:0] csum;

  always_ff @(posedge clk) begin
    if (reset)         csum <= '0;
    else if (start_ok) csum <= '0;
    else if (word_vld) csum <= csum + word;
  end

  assign io.checksum = csum;
`endif
endmodule

// File: tb/tb_dt_pack.sv
// Randomized self-checking bench for dt_pack against a frame-timeline model.
module tb_dt_pack;
  import dt_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  dt_pack_if io();

  dt_pack dut (.clk(clk), .reset(reset), .io(io));

  always #5 clk = ~clk;

  logic [7:0]  mem [NPIX];
  logic [15:0] expw [NWORD];
  logic [15:0] caps [NWORD];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // distance map: data returned the cycle after the read strobe
  always @(posedge clk) if (io.res_rd) io.res_di <= mem[io.res_addr];

  logic       s_start = 1'b0;
  logic       s_reset = 1'b1;
  logic [7:0] s_thr   = '0;
  always @(posedge clk) begin
    s_start <= io.start;
    s_reset <= reset;
    s_thr   <= io.thr;
  end

  // model: ph = cycles since t0, -1 when idle
  int          ph = -1;
  int          ncyc = 0;
  int          cap_cnt = 0;
  int          done_cnt = 0;
  int          done_ph = -1;
  logic [7:0]  m_thr = '0;
  logic [13:0] m_res_addr = '0;
  logic [9:0]  m_pk_addr = '0;
  logic [15:0] m_pk_do = '0;
  logic [15:0] m_sum = '0;

  always @(negedge clk) begin
    logic        wr;
    logic [43:0] expv, actv;
    ncyc++;
    if (s_reset) begin
      ph = -1; m_res_addr = '0; m_pk_addr = '0; m_pk_do = '0; m_sum = '0;
    end else if (ph < 0) begin
      if (s_start) begin
        ph = 0;
        m_thr = s_thr;
        m_sum = '0;
        for (int w = 0; w < NWORD; w++)
          for (int i = 0; i < 16; i++)
            expw[w][15-i] = (mem[16*w+i] >= m_thr);
      end
    end else if (ph == 16386) begin
      ph = -1;
    end else begin
      ph++;
    end
    if (ph >= 0 && ph <= 16383) m_res_addr = 14'(ph);
    wr = (ph >= 17 && ph <= 16385 && ((ph - 17) % 16) == 0);
    if (wr) begin
      m_pk_addr = 10'((ph - 17) / 16);
      m_pk_do   = expw[m_pk_addr];
      m_sum     = m_sum + m_pk_do;
    end
    expv = {(ph >= 0 && ph <= 16385), (ph == 16386), (ph >= 0 && ph <= 16383),
            m_res_addr, wr, m_pk_addr, m_pk_do};
    actv = {io.busy, io.done, io.res_rd, io.res_addr, io.pk_wr, io.pk_addr, io.pk_do};
    if (ncyc > 1) chk($sformatf("outputs@ph%0d", ph), longint'(actv), longint'(expv));
    if (io.pk_wr) begin
      caps[io.pk_addr] = io.pk_do;
      cap_cnt++;
    end
    if (io.done) begin
      done_cnt++;
      done_ph = ph;
`ifdef DT_PACK_CHECKSUM_EN
      chk("checksum@done", longint'(io.checksum), longint'(m_sum));
`endif
    end
  end

  task automatic start_frame(input logic [7:0] t);
    @(negedge clk);
    io.start = 1'b1;
    io.thr   = t;
    @(negedge clk);
    io.start = 1'b0;
    io.thr   = 8'($urandom);
  endtask

  task automatic wait_done(input string nm, input bit start_at_done);
    int n = 0;
    while (!io.done && n < 17000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " done seen"}, longint'(io.done), 1);
    if (start_at_done) io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
  endtask

  task automatic fill_rand();
    for (int p = 0; p < NPIX; p++) mem[p] = 8'($urandom);
  endtask

  initial begin
    int c0, d0;
    io.start = 1'b0;
    io.thr   = '0;
    for (int p = 0; p < NPIX; p++) mem[p] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset state", longint'({io.busy, io.done, io.res_rd, io.pk_wr,
                                 io.res_addr, io.pk_addr, io.pk_do}), 0);

    // all-zero map, thr=1
    c0 = cap_cnt; d0 = done_cnt;
    start_frame(8'd1);
    wait_done("zero", 1'b0);
    chk("zero writes", cap_cnt - c0, 1024);
    chk("zero done cnt", done_cnt - d0, 1);
    chk("zero done ph", done_ph, 16386);
    chk("zero w0", caps[0], 16'h0000);
    chk("zero w1023", caps[1023], 16'h0000);

    // ramp map, thr=128
    for (int p = 0; p < NPIX; p++) mem[p] = 8'(p);
    start_frame(8'd128);
    wait_done("ramp", 1'b0);
    chk("ramp w0", caps[0], 16'h0000);
    chk("ramp w7", caps[7], 16'h0000);
    chk("ramp w8", caps[8], 16'hFFFF);
    chk("ramp w15", caps[15], 16'hFFFF);
    chk("ramp w16", caps[16], 16'h0000);
    chk("ramp w1023", caps[1023], 16'hFFFF);

    // random map, thr=0
    fill_rand();
    start_frame(8'd0);
    wait_done("thr0", 1'b0);
    chk("thr0 w0", caps[0], 16'hFFFF);
    chk("thr0 w500", caps[500], 16'hFFFF);
`ifdef DT_PACK_CHECKSUM_EN
    chk("thr0 checksum", longint'(io.checksum), 16'hFC00);
`endif

    // single pixel at row 0 col 3, thr=5; start collides with done
    for (int p = 0; p < NPIX; p++) mem[p] = '0;
    mem[3] = 8'd5;
    c0 = cap_cnt;
    start_frame(8'd5);
    wait_done("single", 1'b1);
    chk("single w0", caps[0], 16'h1000);
    chk("single w1", caps[1], 16'h0000);
    chk("single writes", cap_cnt - c0, 1024);
    repeat (3) @(negedge clk);
    chk("start at done ignored", longint'(io.busy), 0);

    // reset mid-frame at t0+500
    fill_rand();
    start_frame(8'($urandom_range(1, 255)));
    repeat (500) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("after reset", longint'({io.busy, io.done, io.res_rd, io.pk_wr,
                                 io.res_addr, io.pk_addr, io.pk_do}), 0);
    c0 = cap_cnt;
    repeat (40) @(negedge clk);
    chk("no writes after reset", cap_cnt - c0, 0);

    // full frame after reset, with a stray start at t0+100
    fill_rand();
    c0 = cap_cnt; d0 = done_cnt;
    start_frame(8'($urandom_range(1, 255)));
    repeat (100) @(negedge clk);
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    wait_done("restart", 1'b0);
    repeat (20) @(negedge clk);
    chk("restart writes", cap_cnt - c0, 1024);
    chk("restart done cnt", done_cnt - d0, 1);
    chk("restart idle", longint'(io.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dt_pack.md
DT_PACK -- requirements
Module: dt_pack

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all flops update on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous reset, active-high.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to begin a frame; sampled only in IDLE.
REQ-004 SHALL have port thr, input, 8 bits: distance threshold; latched when start is accepted.
REQ-005 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.
REQ-007 SHALL have port res_rd, output, 1 bit: read strobe to the 16384x8 distance map.
REQ-008 SHALL have port res_addr, output, 14 bits: pixel address, row*128 + col.
REQ-009 SHALL have port res_di, input, 8 bits: read data, valid the cycle after res_rd/res_addr.
REQ-010 SHALL have port pk_wr, output, 1 bit: write strobe to the 1024x16 packed bitmap.
REQ-011 SHALL have port pk_addr, output, 10 bits: word address, row*8 + col/16.
REQ-012 SHALL have port pk_do, output, 16 bits: packed word.

Function
REQ-013 SHALL implement states IDLE -> READ on accepted start -> FLUSH after the last read is issued -> DONE after the last write -> IDLE, with DONE lasting one cycle.
REQ-014 SHALL accept start only in IDLE and ignore start in every other state.
REQ-015 SHALL issue one read per cycle: with t0 the cycle after start is sampled, the read of pixel p (0..16383) has res_rd=1 and res_addr=p at cycle t0+p.
REQ-016 SHALL sample res_di for pixel p at cycle t0+p+1 and compute its bit as 1 when res_di >= latched thr, else 0 (unsigned compare; thr=0 gives all ones).
REQ-017 SHALL place pixel col c into bit 15-(c mod 16), MSB-first.
REQ-018 SHALL write word w (pixels 16w..16w+15) with pk_wr=1, pk_addr=w and pk_do=the packed bits at cycle t0+16w+17, one cycle only.
REQ-019 SHALL drive the last write (w=1023) at t0+16385 and pulse done=1 at t0+16386.
REQ-020 SHALL hold busy=1 from t0 through t0+16385 inclusive and 0 otherwise.
REQ-021 SHALL drive res_rd=0 outside t0..t0+16383, pk_wr=0 except on write cycles, and hold res_addr, pk_addr and pk_do stable between strobes.
REQ-022 SHALL NOT wrap addresses: res_addr stops at 16383 and pk_addr at 1023.
REQ-023 SHALL let a start that coincides with done be ignored; the next frame needs start in IDLE.

Reset
REQ-024 SHALL, when reset=1 at a rising edge, enter IDLE and clear busy, done, res_rd, res_addr, pk_wr, pk_addr, pk_do, the shift register and the latched thr to 0.
REQ-025 SHALL abandon a frame on reset mid-frame with no further pk_wr; a later start restarts from pixel 0.
REQ-026 SHALL give reset priority over start in the same cycle.

Configuration
REQ-027 SHALL, when DT_PACK_CHECKSUM_EN is defined, add output checksum (16 bits) equal to the sum mod 2^16 of all pk_do written this frame; it clears on accepted start and reset and is valid and stable from the done pulse until the next accepted start.
REQ-028 SHALL, when DT_PACK_CHECKSUM_EN is undefined, have no checksum port or logic; all other behaviour is identical.

Structure
REQ-029 SHALL place IMG_W=128, IMG_H=128, WORD_W=16, RES_AW=14, PK_AW=10 and the state enum (IDLE, READ, FLUSH, DONE) in shared package dt_pkg.
REQ-030 SHALL put the threshold-compare and 16-bit MSB-first shift/pack logic in sub-module dt_pack_shift, which outputs a word-valid pulse; the FSM and address counters stay in dt_pack.

Verification
REQ-031 SHALL cover: all-zero map, thr=1 -> 1024 writes of 0x0000, pk_addr 0..1023 in order, done at t0+16386.
REQ-032 SHALL cover: res[p]=p[7:0], thr=128 -> words alternate 8 x 0x0000 and 8 x 0xFFFF.
REQ-033 SHALL cover: any map, thr=0 -> all words 0xFFFF; with DT_PACK_CHECKSUM_EN, checksum=0xFC00.
REQ-034 SHALL cover: map value 5 only at row 0 col 3, thr=5 -> word 0 = 0x1000, all other words 0x0000.
REQ-035 SHALL cover: reset at t0+500 -> all outputs 0 next edge and no pk_wr; a new start gives a full correct frame.
REQ-036 SHALL cover: start pulsed at t0+100 -> ignored, exactly 1024 writes and one done.
